issue_scheduler: RTL and testbench

- Unified reservation station and select logic in front of the three-unit issue stage: FU0/FU1 are ALUs, FU2 is the memory-address/load unit.
- Accepts one renamed instruction per cycle and holds it until both sources are ready.
- Captures operands from the forwarding bus and issues the oldest ready instructions to free functional units, one per unit per cycle.

---
 rtl/issue_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Unified reservation station plus select logic for a three-unit issue stage.
// FU0 and FU1 are ALUs; FU2 is the memory-address/load unit. One renamed
// instruction may be dispatched per cycle. It waits in the station until both
// source operands are valid. Operands are captured from the forwarding bus.
// The oldest ready instructions issue to free units, one per unit per cycle.
//
// Dispatch handshake: an instruction is accepted at a rising edge when
// i_alloc_valid && o_alloc_ready && !i_flush. o_alloc_ready depends only on
// registered occupancy, never on this cycle's alloc, wake or issue inputs.
//
// Ports
//   i_clk, i_rst_n       clock; synchronous active-low reset
//   i_flush              squash every entry and any pending issue
//   i_alloc_*            dispatch request: class, two sources {tag,rdy,data},
//                        and an opaque payload
//   o_alloc_ready        at least one entry is free
//   i_wake_valid/tag/data  per-FU forwarding bus; FU k uses slice k
//   i_fu_ready           FU k can accept an instruction at the next edge
//   o_issue_valid        one-cycle issue strobe per FU
//   o_issue_src0/src1    operands per FU, in FU slices
//   o_issue_payload      payload per FU, in FU slices
//   o_count              number of occupied entries
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int RS_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 48
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_flush,
    input  logic                             i_alloc_valid,
    output logic                             o_alloc_ready,
    input  logic                             i_alloc_is_mem,
    input  logic [PREG_W-1:0]                i_alloc_src0_tag,
    input  logic [PREG_W-1:0]                i_alloc_src1_tag,
    input  logic                             i_alloc_src0_rdy,
    input  logic                             i_alloc_src1_rdy,
    input  logic [DATA_W-1:0]                i_alloc_src0_data,
    input  logic [DATA_W-1:0]                i_alloc_src1_data,
    input  logic [PAYLOAD_W-1:0]             i_alloc_payload,
    input  logic [2:0]                       i_wake_valid,
    input  logic [3*PREG_W-1:0]              i_wake_tag,
    input  logic [3*DATA_W-1:0]              i_wake_data,
    input  logic [2:0]                       i_fu_ready,
    output logic [2:0]                       o_issue_valid,
    output logic [3*DATA_W-1:0]              o_issue_src0,
    output logic [3*DATA_W-1:0]              o_issue_src1,
    output logic [3*PAYLOAD_W-1:0]           o_issue_payload,
    output logic [$clog2(RS_DEPTH+1)-1:0]    o_count
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RS_DEPTH);

    // older[i][j] = 1 means entry i was allocated before entry j.
    // This relation is only meaningful while both entries are valid.
    typedef logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_mat_t;

    // Entry storage
    logic [RS_DEPTH-1:0]  e_valid;
    logic [RS_DEPTH-1:0]  e_is_mem;
    logic [RS_DEPTH-1:0]  e_rdy0;
    logic [RS_DEPTH-1:0]  e_rdy1;
    logic [PREG_W-1:0]    e_tag0    [RS_DEPTH];
    logic [PREG_W-1:0]    e_tag1    [RS_DEPTH];
    logic [DATA_W-1:0]    e_data0   [RS_DEPTH];
    logic [DATA_W-1:0]    e_data1   [RS_DEPTH];
    logic [PAYLOAD_W-1:0] e_payload [RS_DEPTH];
    age_mat_t             older;

    // Select and allocate datapath
    logic [RS_DEPTH-1:0]  elig;
    logic [RS_DEPTH-1:0]  alu_a;
    logic [RS_DEPTH-1:0]  alu_b;
    logic [RS_DEPTH-1:0]  mem_a;
    logic [RS_DEPTH-1:0]  sel0;
    logic [RS_DEPTH-1:0]  sel1;
    logic [RS_DEPTH-1:0]  sel2;
    logic [RS_DEPTH-1:0]  freed;
    logic [RS_DEPTH-1:0]  free_oh;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     iss_idx [3];
    logic [2:0]           iss_v;
    logic [CNT_W-1:0]     n_issued;
    logic                 alloc_fire;
    logic [DATA_W:0]      wk0 [RS_DEPTH];
    logic [DATA_W:0]      wk1 [RS_DEPTH];
    logic [DATA_W:0]      wka0;
    logic [DATA_W:0]      wka1;

    // A candidate is the oldest when no other candidate is older than it.
    function automatic logic [RS_DEPTH-1:0] oldest_of(input logic [RS_DEPTH-1:0] cand,
                                                      input age_mat_t age);
        logic [RS_DEPTH-1:0] pick;
        pick = cand;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (cand[j] && age[j][i]) pick[i] = 1'b0;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [RS_DEPTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Returns {hit, data}. The scan runs from FU2 down to FU0, so when several
    // forwards match, the lowest FU index wins.
    function automatic logic [DATA_W:0] wake_match(input logic [PREG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int k = 2; k >= 0; k--) begin
            if (i_wake_valid[k] && (i_wake_tag[k*PREG_W +: PREG_W] == tag))
                res = {1'b1, i_wake_data[k*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    assign o_alloc_ready = (o_count < DEPTH_CNT);

    always_comb begin
        elig  = e_valid & e_rdy0 & e_rdy1;
        alu_a = oldest_of(elig & ~e_is_mem, older);
        alu_b = oldest_of(elig & ~e_is_mem & ~alu_a, older);
        mem_a = oldest_of(elig & e_is_mem, older);

        // The oldest ALU op goes to FU0 when it can take it. Otherwise it goes
        // to FU1. The runner-up is used only when both ALUs are ready.
        sel0 = i_fu_ready[0] ? alu_a : '0;
        sel1 = !i_fu_ready[1] ? '0 : (i_fu_ready[0] ? alu_b : alu_a);
        sel2 = i_fu_ready[2] ? mem_a : '0;

        iss_v      = {|sel2, |sel1, |sel0};
        freed      = sel0 | sel1 | sel2;
        iss_idx[0] = to_idx(sel0);
        iss_idx[1] = to_idx(sel1);
        iss_idx[2] = to_idx(sel2);
        n_issued   = CNT_W'(iss_v[0]) + CNT_W'(iss_v[1]) + CNT_W'(iss_v[2]);

        // Lowest-index free entry. The scan runs downward, so the last write wins.
        free_idx = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (!e_valid[i]) free_idx = IDX_W'(i);
        end
        free_oh           = '0;
        free_oh[free_idx] = |(~e_valid);

        alloc_fire = i_alloc_valid && o_alloc_ready && !i_flush;

        for (int i = 0; i < RS_DEPTH; i++) begin
            wk0[i] = wake_match(e_tag0[i]);
            wk1[i] = wake_match(e_tag1[i]);
        end
        wka0 = wake_match(i_alloc_src0_tag);
        wka1 = wake_match(i_alloc_src1_tag);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            e_valid         <= '0;
            e_is_mem        <= '0;
            e_rdy0          <= '0;
            e_rdy1          <= '0;
            older           <= '0;
            o_issue_valid   <= '0;
            o_issue_src0    <= '0;
            o_issue_src1    <= '0;
            o_issue_payload <= '0;
            o_count         <= '0;
        end else if (i_flush) begin
            e_valid       <= '0;
            o_issue_valid <= '0;
            o_count       <= '0;
        end else begin
            o_issue_valid <= iss_v;
            for (int k = 0; k < 3; k++) begin
                if (iss_v[k]) begin
                    o_issue_src0[k*DATA_W +: DATA_W]          <= e_data0[iss_idx[k]];
                    o_issue_src1[k*DATA_W +: DATA_W]          <= e_data1[iss_idx[k]];
                    o_issue_payload[k*PAYLOAD_W +: PAYLOAD_W] <= e_payload[iss_idx[k]];
                end
            end

            for (int i = 0; i < RS_DEPTH; i++) begin
                if (!e_rdy0[i] && wk0[i][DATA_W]) begin
                    e_rdy0[i]  <= 1'b1;
                    e_data0[i] <= wk0[i][DATA_W-1:0];
                end
                if (!e_rdy1[i] && wk1[i][DATA_W]) begin
                    e_rdy1[i]  <= 1'b1;
                    e_data1[i] <= wk1[i][DATA_W-1:0];
                end
            end

            e_valid <= (e_valid & ~freed) | (alloc_fire ? free_oh : '0);

            // The allocated entry's fields are written after the wake loop, so
            // they override any stale wake capture into that slot.
            if (alloc_fire) begin
                e_is_mem[free_idx]  <= i_alloc_is_mem;
                e_tag0[free_idx]    <= i_alloc_src0_tag;
                e_tag1[free_idx]    <= i_alloc_src1_tag;
                e_rdy0[free_idx]    <= i_alloc_src0_rdy | wka0[DATA_W];
                e_rdy1[free_idx]    <= i_alloc_src1_rdy | wka1[DATA_W];
                e_data0[free_idx]   <= i_alloc_src0_rdy ? i_alloc_src0_data : wka0[DATA_W-1:0];
                e_data1[free_idx]   <= i_alloc_src1_rdy ? i_alloc_src1_data : wka1[DATA_W-1:0];
                e_payload[free_idx] <= i_alloc_payload;
                // Every resident entry is older than the newcomer.
                for (int j = 0; j < RS_DEPTH; j++) begin
                    older[j][free_idx] <= e_valid[j];
                end
                older[free_idx] <= '0;
            end

            o_count <= o_count + CNT_W'(alloc_fire) - n_issued;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//
// Self-checking bench for issue_scheduler. The reference model keeps the
// resident instructions in a queue in age order. Before each edge it computes
// which instructions issue. It pushes the expected {fu, payload, src0, src1}
// words onto exp_q. A monitor pops one word per issue strobe after the edge.
// Directed scenarios run first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;

    localparam int DEPTH = 8;
    localparam int PW    = 6;
    localparam int DW    = 32;
    localparam int PLW   = 48;
    localparam int CW    = 4;
    localparam int EXP_W = 2 + PLW + 2*DW;

    // Clock and reset
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic              i_rst_n;
    logic              i_flush;
    logic              i_alloc_valid;
    logic              o_alloc_ready;
    logic              i_alloc_is_mem;
    logic [PW-1:0]     i_alloc_src0_tag, i_alloc_src1_tag;
    logic              i_alloc_src0_rdy, i_alloc_src1_rdy;
    logic [DW-1:0]     i_alloc_src0_data, i_alloc_src1_data;
    logic [PLW-1:0]    i_alloc_payload;
    logic [2:0]        i_wake_valid;
    logic [3*PW-1:0]   i_wake_tag;
    logic [3*DW-1:0]   i_wake_data;
    logic [2:0]        i_fu_ready;
    logic [2:0]        o_issue_valid;
    logic [3*DW-1:0]   o_issue_src0, o_issue_src1;
    logic [3*PLW-1:0]  o_issue_payload;
    logic [CW-1:0]     o_count;

    issue_scheduler #(.RS_DEPTH(DEPTH), .PREG_W(PW), .DATA_W(DW), .PAYLOAD_W(PLW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
        .i_alloc_is_mem(i_alloc_is_mem),
        .i_alloc_src0_tag(i_alloc_src0_tag), .i_alloc_src1_tag(i_alloc_src1_tag),
        .i_alloc_src0_rdy(i_alloc_src0_rdy), .i_alloc_src1_rdy(i_alloc_src1_rdy),
        .i_alloc_src0_data(i_alloc_src0_data), .i_alloc_src1_data(i_alloc_src1_data),
        .i_alloc_payload(i_alloc_payload),
        .i_wake_valid(i_wake_valid), .i_wake_tag(i_wake_tag), .i_wake_data(i_wake_data),
        .i_fu_ready(i_fu_ready), .o_issue_valid(o_issue_valid),
        .o_issue_src0(o_issue_src0), .o_issue_src1(o_issue_src1),
        .o_issue_payload(o_issue_payload), .o_count(o_count)
    );

    // Reference model state and scoreboard
    typedef struct {
        logic           is_mem;
        logic [PW-1:0]  t0;
        logic           r0;
        logic [DW-1:0]  d0;
        logic [PW-1:0]  t1;
        logic           r1;
        logic [DW-1:0]  d1;
        logic [PLW-1:0] pl;
    } ent_t;

    ent_t             rs_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               n_vec  = 0;
    int               n_fail = 0;
    int               pl_id  = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // First matching forward in FU order: lowest k wins.
    function automatic logic [DW:0] wake_find(input logic [PW-1:0] t);
        for (int k = 0; k < 3; k++) begin
            if (i_wake_valid[k] && i_wake_tag[k*PW +: PW] == t)
                return {1'b1, i_wake_data[k*DW +: DW]};
        end
        return '0;
    endfunction

    // Computes the effect of the upcoming edge from the current inputs.
    task automatic model_step();
        ent_t        n_q[$];
        ent_t        e;
        int          a, b, m, f0, f1, f2;
        logic        accept;
        logic [DW:0] w;
        if (!i_rst_n || i_flush) begin
            rs_q.delete();
            return;
        end
        accept = i_alloc_valid && (rs_q.size() < DEPTH);
        a = -1; b = -1; m = -1;
        for (int i = 0; i < rs_q.size(); i++) begin
            if (rs_q[i].r0 && rs_q[i].r1) begin
                if (rs_q[i].is_mem) begin
                    if (m < 0) m = i;
                end else if (a < 0) a = i;
                else if (b < 0) b = i;
            end
        end
        f0 = i_fu_ready[0] ? a : -1;
        f1 = i_fu_ready[1] ? (i_fu_ready[0] ? b : a) : -1;
        f2 = i_fu_ready[2] ? m : -1;
        if (f0 >= 0) exp_q.push_back({2'd0, rs_q[f0].pl, rs_q[f0].d0, rs_q[f0].d1});
        if (f1 >= 0) exp_q.push_back({2'd1, rs_q[f1].pl, rs_q[f1].d0, rs_q[f1].d1});
        if (f2 >= 0) exp_q.push_back({2'd2, rs_q[f2].pl, rs_q[f2].d0, rs_q[f2].d1});
        for (int i = 0; i < rs_q.size(); i++) begin
            if (i != f0 && i != f1 && i != f2) begin
                e = rs_q[i];
                if (!e.r0) begin w = wake_find(e.t0); if (w[DW]) begin e.r0 = 1'b1; e.d0 = w[DW-1:0]; end end
                if (!e.r1) begin w = wake_find(e.t1); if (w[DW]) begin e.r1 = 1'b1; e.d1 = w[DW-1:0]; end end
                n_q.push_back(e);
            end
        end
        if (accept) begin
            e.is_mem = i_alloc_is_mem;
            e.t0 = i_alloc_src0_tag; e.r0 = i_alloc_src0_rdy; e.d0 = i_alloc_src0_rdy ? i_alloc_src0_data : '0;
            e.t1 = i_alloc_src1_tag; e.r1 = i_alloc_src1_rdy; e.d1 = i_alloc_src1_rdy ? i_alloc_src1_data : '0;
            e.pl = i_alloc_payload;
            if (!e.r0) begin w = wake_find(e.t0); if (w[DW]) begin e.r0 = 1'b1; e.d0 = w[DW-1:0]; end end
            if (!e.r1) begin w = wake_find(e.t1); if (w[DW]) begin e.r1 = 1'b1; e.d1 = w[DW-1:0]; end end
            n_q.push_back(e);
        end
        rs_q = n_q;
    endtask

    // Driver tasks
    task automatic cycle();
        model_step();
        @(negedge i_clk);
        chk("count", o_count, rs_q.size());
        chk("alloc_ready", o_alloc_ready, rs_q.size() < DEPTH);
    endtask

    task automatic idle_inputs();
        i_alloc_valid = 1'b0;
        i_wake_valid  = '0;
        i_flush       = 1'b0;
    endtask

    task automatic set_alloc(input logic mem, input logic [PW-1:0] t0, input logic r0,
                             input logic [DW-1:0] d0, input logic [PW-1:0] t1,
                             input logic r1, input logic [DW-1:0] d1);
        i_alloc_valid     = 1'b1;
        i_alloc_is_mem    = mem;
        i_alloc_src0_tag  = t0; i_alloc_src0_rdy = r0; i_alloc_src0_data = d0;
        i_alloc_src1_tag  = t1; i_alloc_src1_rdy = r1; i_alloc_src1_data = d1;
        i_alloc_payload   = {16'(pl_id * 7 + 16'h3c00), 32'(pl_id)};
        pl_id++;
    endtask

    task automatic set_wake(input int k, input logic [PW-1:0] t, input logic [DW-1:0] d);
        i_wake_valid[k]          = 1'b1;
        i_wake_tag[k*PW +: PW]   = t;
        i_wake_data[k*DW +: DW]  = d;
    endtask

    task automatic flush_cycle();
        idle_inputs();
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
    endtask

    // Monitor: every issue strobe must match the next expected word, and
    // nothing expected for this edge may remain unconsumed.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge i_clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (o_issue_valid[k] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("issue_unexpected", {2'(k), o_issue_payload[k*PLW +: PLW]}, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("issue_word", {2'(k), o_issue_payload[k*PLW +: PLW],
                                           o_issue_src0[k*DW +: DW], o_issue_src1[k*DW +: DW]}, e);
                    end
                end
            end
            chk("issue_missing", exp_q.size(), 0);
            exp_q.delete();
        end
    end

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_fu_ready = 3'b111;
        i_wake_valid = '0; i_wake_tag = '0; i_wake_data = '0;
        set_alloc(1'b0, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9);

        // Reset held for two cycles with alloc requested
        cycle();
        cycle();
        chk("reset_issue_valid", o_issue_valid, 3'b000);
        chk("reset_src0", o_issue_src0, '0);
        chk("reset_payload", o_issue_payload, '0);
        i_rst_n = 1'b1;

        // Ready-at-dispatch: src0=5, src1=7
        idle_inputs();
        set_alloc(1'b0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
        cycle();
        chk("first_alloc_count", o_count, 1);
        idle_inputs();
        cycle();
        chk("rdy_dispatch_valid", o_issue_valid, 3'b001);
        chk("rdy_dispatch_src0", o_issue_src0[DW-1:0], 32'd5);
        chk("rdy_dispatch_src1", o_issue_src1[DW-1:0], 32'd7);

        // Wake two cycles after allocation
        idle_inputs();
        set_alloc(1'b0, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'h11);
        cycle();
        idle_inputs(); cycle();
        idle_inputs(); set_wake(1, 6'd12, 32'hDEAD); cycle();
        idle_inputs(); cycle();
        chk("wake_issue_valid", o_issue_valid, 3'b001);
        chk("wake_issue_src0", o_issue_src0[DW-1:0], 32'hDEAD);

        // Wake in the allocation cycle
        idle_inputs();
        set_alloc(1'b0, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'h22);
        set_wake(1, 6'd12, 32'hBEEF);
        cycle();
        idle_inputs(); cycle();
        chk("bypass_issue_valid", o_issue_valid, 3'b001);
        chk("bypass_issue_src0", o_issue_src0[DW-1:0], 32'hBEEF);

        // Age order with both ALUs ready: I0/I1, then I2/I3
        i_fu_ready = 3'b011;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            set_alloc(1'b0, 6'd20, 1'b0, 32'd0, 6'd4, 1'b1, 32'(100 + i));
            cycle();
        end
        idle_inputs(); set_wake(0, 6'd20, 32'h5050); cycle();
        idle_inputs(); cycle();
        chk("age_pair1_valid", o_issue_valid, 3'b011);
        idle_inputs(); cycle();
        chk("age_pair2_valid", o_issue_valid, 3'b011);

        // Only FU1 ready: the oldest op goes to FU1
        i_fu_ready = 3'b010;
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            set_alloc(1'b0, 6'd30, 1'b0, 32'd0, 6'd4, 1'b1, 32'(200 + i));
            cycle();
        end
        idle_inputs(); set_wake(2, 6'd30, 32'h3030); cycle();
        idle_inputs(); cycle();
        chk("fu1_only_valid", o_issue_valid, 3'b010);
        idle_inputs(); cycle();
        idle_inputs(); cycle();

        // Full station and backpressure
        i_fu_ready = 3'b111;
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            set_alloc(1'b0, 6'(40 + i), 1'b0, 32'd0, 6'd4, 1'b1, 32'(300 + i));
            cycle();
        end
        chk("full_count", o_count, 8);
        chk("full_ready", o_alloc_ready, 1'b0);
        idle_inputs();
        set_alloc(1'b0, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1);
        cycle();
        set_wake(0, 6'd40, 32'h4040);
        cycle();
        i_wake_valid = '0;
        cycle();
        chk("bp_issue_valid", o_issue_valid, 3'b001);
        chk("bp_count_after_issue", o_count, 7);
        cycle();
        chk("bp_alloc_accepted", o_count, 8);
        for (int i = 1; i < DEPTH; i++) begin
            idle_inputs(); set_wake(0, 6'(40 + i), 32'(i * 3)); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); cycle();
        end

        // Mixed traffic: mem issues only when FU2 is ready, oldest first
        flush_cycle();
        i_fu_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); set_alloc(1'b0, 6'd50, 1'b0, 32'd0, 6'd4, 1'b1, 32'(400 + i)); cycle();
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs(); set_alloc(1'b1, 6'd5, 1'b1, 32'(500 + i), 6'd4, 1'b1, 32'd7); cycle();
        end
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            i_fu_ready = {i[0], 2'b00};
            cycle();
        end
        chk("mixed_alu_resident", o_count, 3);

        // Flush with simultaneous alloc and wake
        idle_inputs();
        i_fu_ready = 3'b111;
        set_alloc(1'b0, 6'd7, 1'b1, 32'd8, 6'd7, 1'b1, 32'd8);
        set_wake(0, 6'd50, 32'h6060);
        i_flush = 1'b1;
        cycle();
        chk("flush_count", o_count, 0);
        chk("flush_issue_valid", o_issue_valid, 3'b000);
        idle_inputs(); set_wake(0, 6'd50, 32'h6061); cycle();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); cycle();
        end

        // Randomized traffic with occasional flush and mid-run reset
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            i_rst_n = ($urandom_range(0, 399) != 0);
            i_flush = ($urandom_range(0, 99) == 0);
            set_alloc(($urandom_range(0, 99) < 30),
                      6'($urandom_range(0, 15)), ($urandom_range(0, 99) < 40), $urandom,
                      6'($urandom_range(0, 15)), ($urandom_range(0, 99) < 40), $urandom);
            i_alloc_valid = ($urandom_range(0, 99) < 60);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 1) set_wake(k, 6'($urandom_range(0, 15)), $urandom);
            end
            i_fu_ready = 3'($urandom_range(0, 7));
            cycle();
        end
        i_rst_n = 1'b1;
        idle_inputs();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
